// File: rtl/mon_pkg.sv
// Shared types and defaults for the memory-write monitor.
// Latency: n/a (package only).
// Backpressure: n/a.
package mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PASS    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_t;

  localparam int DEF_TIMEOUT    = 10000;
  localparam int DEF_NUM_CHECKS = 8;
  localparam int DEF_LOG_DEPTH  = 16;

  // Index width that stays legal for a single-entry table.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mon_log_fifo.sv
// Generic first-word fall-through FIFO used for the store log.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: push_rdy low only when full and not popping; pop_vld = not empty.
//
// Ports: clk, reset (async, active-low); push_vld/push_rdy/push_dat in;
//        pop_vld/pop_rdy/pop_dat out. DEPTH must be a power of two >= 2.
module mon_log_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mon_log_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_vld  = !empty;
  assign pop_dat  = mem[rd_ptr[AW-1:0]];
  assign do_pop   = pop_vld && pop_rdy;
  // When full, a pop in the same cycle frees the slot the push lands in.
  assign push_rdy = !full || pop_rdy;
  assign do_push  = push_vld && push_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/mem_write_monitor.sv
// Watches a processor store port for any of a table of expected {addr,data}
// stores and reports pass (with lowest matching entry) or timeout.
// Latency: pass/timeout assert the cycle after the deciding store/cycle.
// Backpressure: none on the store port; log drops stores when full (log_ovf).
//
// Ports: clk, reset (async, active-low); start, memwrite, dataadr, writedata
//        (observed store bus); cfg_we/cfg_idx/cfg_addr/cfg_data/cfg_valid
//        (table write, ignored while running); busy, pass, timeout, pass_idx,
//        cycle_cnt, write_cnt (status).
// Optional macro MON_LOG_EN adds a store log FIFO with log_valid/log_ready/
// log_addr/log_data and a sticky log_ovf drop flag.
module mem_write_monitor
  import mon_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int NUM_CHECKS = DEF_NUM_CHECKS,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int LOG_DEPTH  = DEF_LOG_DEPTH,
  localparam int IDX_W     = idx_width(NUM_CHECKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              busy,
  output logic              pass,
  output logic              timeout,
  output logic [IDX_W-1:0]  pass_idx,
  output logic [CNT_W-1:0]  cycle_cnt,
`ifdef MON_LOG_EN
  output logic              log_valid,
  input  logic              log_ready,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_data,
  output logic              log_ovf,
`endif
  output logic [CNT_W-1:0]  write_cnt
);

  if (LOG_DEPTH < 2 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_bad_log_depth
    $error("mem_write_monitor: LOG_DEPTH must be a power of two >= 2");
  end

  mon_state_t state_q;
  mon_state_t state_d;

  logic [ADDR_W-1:0]     tbl_addr [NUM_CHECKS];
  logic [DATA_W-1:0]     tbl_data [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] tbl_valid;

  logic                  in_run;
  logic                  run_start;
  logic                  store;
  logic                  cfg_ok;
  logic [NUM_CHECKS-1:0] hit;
  logic                  match;
  logic [IDX_W-1:0]      match_idx;
  logic                  tmo_hit;

  assign in_run    = (state_q == ST_RUN);
  // start is meaningless mid-run; from any other state it (re)launches a run.
  assign run_start = start && !in_run;
  assign store     = (memwrite != 2'b00);
  assign cfg_ok    = cfg_we && !in_run && (int'(cfg_idx) < NUM_CHECKS);
  assign tmo_hit   = (cycle_cnt == CNT_W'(TIMEOUT - 1));

  // ---------------- expected-store table ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_valid <= '0;
    end else if (cfg_ok) begin
      tbl_valid[cfg_idx] <= cfg_valid;
    end
  end

  // Address/data payload needs no reset: it is qualified by tbl_valid.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      tbl_addr[cfg_idx] <= cfg_addr;
      tbl_data[cfg_idx] <= cfg_data;
    end
  end

  // ---------------- match detection ----------------
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      hit[i] = tbl_valid[i] && (dataadr == tbl_addr[i]) && (writedata == tbl_data[i]);
    end
  end

  assign match = store && (|hit);

  // Scan downwards so the lowest matching index wins.
  always_comb begin
    match_idx = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (hit[i]) match_idx = IDX_W'(i);
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_PASS, ST_TIMEOUT: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A match on the last allowed cycle still counts as a pass.
        if (match)        state_d = ST_PASS;
        else if (tmo_hit) state_d = ST_TIMEOUT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = in_run;
  assign pass    = (state_q == ST_PASS);
  assign timeout = (state_q == ST_TIMEOUT);

  // ---------------- counters and result index ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      write_cnt <= '0;
      pass_idx  <= '0;
    end else if (run_start) begin
      cycle_cnt <= '0;
      write_cnt <= '0;
      pass_idx  <= '0;
    end else if (in_run) begin
      // Freeze on the deciding cycle so cycle_cnt reports when it happened.
      if (!match && !tmo_hit && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (store && (write_cnt != '1))              write_cnt <= write_cnt + CNT_W'(1);
      if (match)                                   pass_idx  <= match_idx;
    end
  end

`ifdef MON_LOG_EN
  // ---------------- store log ----------------
  logic                     log_push;
  logic                     log_push_rdy;
  logic [ADDR_W+DATA_W-1:0] log_word;

  assign log_push = in_run && store;

  mon_log_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (log_push),
    .push_rdy (log_push_rdy),
    .push_dat ({dataadr, writedata}),
    .pop_vld  (log_valid),
    .pop_rdy  (log_ready),
    .pop_dat  (log_word)
  );

  assign {log_addr, log_data} = log_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          log_ovf <= 1'b0;
    else if (run_start)                  log_ovf <= 1'b0;
    else if (log_push && !log_push_rdy)  log_ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
// Log checks are included when MON_LOG_EN is defined.
module tb_mem_write_monitor;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int NC  = 8;
  localparam int CW  = 32;
  localparam int TMO = 50;
  localparam int LD  = 4;
  localparam int IW  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    memwrite = 2'b00;
  logic [AW-1:0] dataadr = '0;
  logic [DW-1:0] writedata = '0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          busy;
  logic          pass;
  logic          timeout;
  logic [IW-1:0] pass_idx;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] write_cnt;
`ifdef MON_LOG_EN
  logic          log_valid;
  logic          log_ready = 1'b0;
  logic [AW-1:0] log_addr;
  logic [DW-1:0] log_data;
  logic          log_ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_write_monitor #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .NUM_CHECKS (NC),
    .CNT_W      (CW),
    .TIMEOUT    (TMO),
    .LOG_DEPTH  (LD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .pass      (pass),
    .timeout   (timeout),
    .pass_idx  (pass_idx),
    .cycle_cnt (cycle_cnt),
`ifdef MON_LOG_EN
    .log_valid (log_valid),
    .log_ready (log_ready),
    .log_addr  (log_addr),
    .log_data  (log_data),
    .log_ovf   (log_ovf),
`endif
    .write_cnt (write_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic v);
    cfg_we    = 1'b1;
    cfg_idx   = IW'(idx);
    cfg_addr  = a;
    cfg_data  = d;
    cfg_valid = v;
    tick(1);
    cfg_we    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] mw);
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    tick(1);
    memwrite  = 2'b00;
  endtask

  initial begin
    // ---- reset state ----
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_cyc", cycle_cnt, 0);
    reset = 1'b1;
    tick(1);
    check("idle_busy", busy, 0);
    check("idle_pass", pass, 0);
    check("idle_tmo", timeout, 0);
    check("idle_idx", pass_idx, 0);
    check("idle_wcnt", write_cnt, 0);

    // ---- entry0={100,7}, matching store at cycle 40 ----
    cfg(0, 100, 7, 1'b1);
    do_start();
    check("t1_busy", busy, 1);
    check("t1_cyc0", cycle_cnt, 0);
    tick(10);
    store(101, 7, 2'b01);
    store(100, 8, 2'b10);
    tick(28);
    check("t1_cyc40", cycle_cnt, 40);
    check("t1_nopass", pass, 0);
    store(100, 7, 2'b11);
    check("t1_pass", pass, 1);
    check("t1_tmo", timeout, 0);
    check("t1_busy_off", busy, 0);
    check("t1_idx", pass_idx, 0);
    check("t1_cyc", cycle_cnt, 40);
    check("t1_wcnt", write_cnt, 3);
    tick(3);
    check("t1_cyc_hold", cycle_cnt, 40);

    // ---- start ignored in RUN; cfg ignored in RUN ----
    do_start();
    check("t2_pass_clr", pass, 0);
    check("t2_cyc_clr", cycle_cnt, 0);
    tick(5);
    do_start();
    check("t2_start_ign", cycle_cnt, 6);
    cfg(0, 320, 4950, 1'b1);
    store(320, 4950, 2'b01);
    check("t2_cfg_ign_pass", pass, 0);
    check("t2_cfg_ign_busy", busy, 1);
    check("t2_cyc8", cycle_cnt, 8);
    store(100, 7, 2'b01);
    check("t2_old_entry", pass, 1);
    check("t2_wcnt", write_cnt, 2);
    check("t2_cyc", cycle_cnt, 8);

    // ---- priority: entries 2, 5 and 6 ----
    cfg(0, 100, 7, 1'b0);
    cfg(2, 508, 7, 1'b1);
    cfg(5, 80, 1, 1'b1);
    cfg(6, 80, 1, 1'b1);
    do_start();
    store(80, 7, 2'b01);
    check("t3_partial", pass, 0);
    store(80, 1, 2'b10);
    check("t3_pass", pass, 1);
    check("t3_idx5", pass_idx, 5);
    check("t3_cyc", cycle_cnt, 1);
    do_start();
    check("t3_idx_clr", pass_idx, 0);
    store(508, 7, 2'b01);
    check("t3_idx2", pass_idx, 2);

    // ---- timeout at TIMEOUT-1 ----
    do_start();
    tick(49);
    check("t4_cyc49", cycle_cnt, 49);
    check("t4_busy", busy, 1);
    tick(1);
    check("t4_tmo", timeout, 1);
    check("t4_pass", pass, 0);
    check("t4_cyc", cycle_cnt, 49);
    check("t4_busy_off", busy, 0);
    tick(3);
    check("t4_cyc_hold", cycle_cnt, 49);
    do_start();
    check("t4_tmo_clr", timeout, 0);
    tick(49);
    store(80, 1, 2'b01);
    check("t4_lastpass", pass, 1);
    check("t4_lasttmo", timeout, 0);
    check("t4_lastcyc", cycle_cnt, 49);
    check("t4_lastidx", pass_idx, 5);

    // ---- reset mid-run ----
    do_start();
    tick(20);
    check("t5_cyc20", cycle_cnt, 20);
    reset = 1'b0;
    #1;
    check("t5_async_busy", busy, 0);
    check("t5_async_cyc", cycle_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    check("t5_pass", pass, 0);
    check("t5_tmo", timeout, 0);
    check("t5_wcnt", write_cnt, 0);
    check("t5_idx", pass_idx, 0);
    do_start();
    store(80, 1, 2'b01);
    store(508, 7, 2'b10);
    check("t5_novalid", pass, 0);
    tick(47);
    check("t5_busy", busy, 1);
    tick(1);
    check("t5_tmo_only", timeout, 1);
    check("t5_no_pass", pass, 0);
    check("t5_wcnt2", write_cnt, 2);

`ifdef MON_LOG_EN
    // ---- log FIFO overflow and drain ----
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    check("t6_empty", log_valid, 0);
    log_ready = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) store(AW'(200 + i), DW'(16 + i), 2'b01);
    check("t6_no_ovf", log_ovf, 0);
    store(204, 20, 2'b01);
    check("t6_ovf", log_ovf, 1);
    check("t6_vld", log_valid, 1);
    log_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t6_drain_vld", log_valid, 1);
      check("t6_drain_addr", log_addr, 200 + i);
      check("t6_drain_data", log_data, 16 + i);
      tick(1);
    end
    check("t6_drained", log_valid, 0);
    log_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
